// File: rtl/mult_par_pkg.sv
// Shared types and limits for the sequential signed multiplier with operand parity.
package mult_par_pkg;

    localparam int MIN_WIDTH = 4;
    localparam int MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        CALC,
        DONE
    } state_t;

endpackage

// File: rtl/parity_gen.sv
// Even-parity generator: XOR reduction of an N-bit word.
module parity_gen #(
    parameter int N = 8
) (
    input  logic [N-1:0] data,
    output logic         parity
);

    assign parity = ^data;

endmodule

// File: rtl/mult_par_seq.sv
// Sequential signed shift-add multiplier with parity-protected operands and result.
// Operand parity checking is compiled in only when MULT_PAR_SEQ_PARITY_CHECK_EN is defined.
module mult_par_seq
    import mult_par_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     arg_a,
    input  logic                 arg_a_parity,
    input  logic [WIDTH-1:0]     arg_b,
    input  logic                 arg_b_parity,
    input  logic                 req,
    output logic                 ack,
    output logic [2*WIDTH-1:0]   result,
    output logic                 result_parity,
    output logic                 result_rdy,
    output logic                 arg_parity_error
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    generate
        if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_width_check
            $error("mult_par_seq: WIDTH=%0d outside legal range %0d..%0d",
                   WIDTH, MIN_WIDTH, MAX_WIDTH);
        end
    endgenerate

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [PW-1:0]    a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             a_par_reg, b_par_reg;
    logic [PW-1:0]    acc_reg, acc_next, pp;
    logic [PW-1:0]    result_reg;
    logic             result_parity_reg;
    logic             err_reg;
    logic             acc_parity;
    logic             par_err;
    logic             capture;
    logic             last_iter;

`ifdef MULT_PAR_SEQ_PARITY_CHECK_EN
    logic a_xor, b_xor;

    parity_gen #(.N(WIDTH)) u_par_a (.data(a_reg[WIDTH-1:0]), .parity(a_xor));
    parity_gen #(.N(WIDTH)) u_par_b (.data(b_reg),            .parity(b_xor));

    assign par_err = (a_xor != a_par_reg) || (b_xor != b_par_reg);
`else
    logic unused_parity;

    assign unused_parity = a_par_reg ^ b_par_reg;
    assign par_err       = 1'b0;
`endif

    // b is consumed LSB first; its MSB carries weight -2^(WIDTH-1), so the last step subtracts.
    assign last_iter = (state_reg == CALC) && (cnt_reg == LAST_CNT);
    assign pp        = b_reg[0] ? a_reg : '0;
    assign acc_next  = last_iter ? (acc_reg - pp) : (acc_reg + pp);

    parity_gen #(.N(PW)) u_par_res (.data(acc_next), .parity(acc_parity));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        ack        = 1'b0;
        result_rdy = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    capture    = 1'b1;
                    state_next = CHECK;
                end
            end
            CHECK: begin
                ack        = 1'b1;
                state_next = par_err ? DONE : CALC;
            end
            CALC: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                result_rdy = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg           <= '0;
            a_reg             <= '0;
            b_reg             <= '0;
            a_par_reg         <= 1'b0;
            b_par_reg         <= 1'b0;
            acc_reg           <= '0;
            result_reg        <= '0;
            result_parity_reg <= 1'b0;
            err_reg           <= 1'b0;
        end else begin
            if (capture) begin
                a_reg     <= {{WIDTH{arg_a[WIDTH-1]}}, arg_a};
                b_reg     <= arg_b;
                a_par_reg <= arg_a_parity;
                b_par_reg <= arg_b_parity;
            end else if (state_reg == CALC) begin
                a_reg <= a_reg << 1;
                b_reg <= b_reg >> 1;
            end

            if (state_reg == CHECK) begin
                cnt_reg <= '0;
                acc_reg <= '0;
            end else if (state_reg == CALC) begin
                cnt_reg <= cnt_reg + 1'b1;
                acc_reg <= acc_next;
            end

            if ((state_reg == CHECK) && par_err) begin
                result_reg        <= '0;
                result_parity_reg <= 1'b0;
                err_reg           <= 1'b1;
            end else if (last_iter) begin
                result_reg        <= acc_next;
                result_parity_reg <= acc_parity;
                err_reg           <= 1'b0;
            end
        end
    end

    assign result           = result_reg;
    assign result_parity    = result_parity_reg;
    assign arg_parity_error = err_reg;

endmodule

// File: tb/tb_mult_par_seq.sv
// Self-checking bench for mult_par_seq: WIDTH=16 and WIDTH=8 instances against an arithmetic model.
module tb_mult_par_seq;

    logic        clk;
    logic        rst_n;

    logic [15:0] a16, b16;
    logic        pa16, pb16, req16;
    logic        ack16, rpar16, rdy16, err16;
    logic [31:0] res16;

    logic [7:0]  a8, b8;
    logic        pa8, pb8, req8;
    logic        ack8, rpar8, rdy8, err8;
    logic [15:0] res8;

    int checks = 0;
    int errors = 0;

    mult_par_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .arg_a(a16), .arg_a_parity(pa16), .arg_b(b16), .arg_b_parity(pb16),
        .req(req16), .ack(ack16), .result(res16), .result_parity(rpar16),
        .result_rdy(rdy16), .arg_parity_error(err16)
    );

    mult_par_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .arg_a(a8), .arg_a_parity(pa8), .arg_b(b8), .arg_b_parity(pb8),
        .req(req8), .ack(ack8), .result(res8), .result_parity(rpar8),
        .result_rdy(rdy8), .arg_parity_error(err8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[31:0];
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[15:0];
    endfunction

    function automatic logic parity_fault(input logic [15:0] a, input logic [15:0] b,
                                          input logic pa, input logic pb);
`ifdef MULT_PAR_SEQ_PARITY_CHECK_EN
        return ((^a) != pa) || ((^b) != pb);
`else
        return 1'b0 & (^{a, b, pa, pb});
`endif
    endfunction

    // One full WIDTH=16 operation: cycle k is the k-th negedge after the capture edge.
    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic pa,
                        input logic pb, input bit toggle, input bit rel);
        logic [31:0] exp_res;
        logic        exp_err;
        int          lat;
        exp_err = parity_fault(a, b, pa, pb);
        exp_res = exp_err ? 32'h0 : ref16(a, b);
        lat     = exp_err ? 2 : 18;
        @(negedge clk);
        if (rel) rst_n = 1'b1;
        a16 = a; b16 = b; pa16 = pa; pb16 = pb; req16 = 1'b1;
        @(negedge clk);
        chk("ack16_pulse", 64'(ack16), 64'(1'b1));
        chk("rdy16_early", 64'(rdy16), 64'(1'b0));
        req16 = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
        for (int k = 2; k <= lat; k++) begin
            @(negedge clk);
            chk("ack16_extra", 64'(ack16), 64'(1'b0));
            chk("rdy16_timing", 64'(rdy16), 64'(k == lat));
            req16 = (toggle && k < lat) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        chk("res16", 64'(res16), 64'(exp_res));
        chk("rpar16", 64'(rpar16), 64'(^exp_res));
        chk("err16", 64'(err16), 64'(exp_err));
        @(negedge clk);
        chk("rdy16_pulse_end", 64'(rdy16), 64'(1'b0));
        chk("res16_hold", 64'(res16), 64'(exp_res));
        chk("err16_hold", 64'(err16), 64'(exp_err));
        $display("op16 a=%0d b=%0d result=%0d parity=%0b err=%0b latency=%0d",
                 $signed(a), $signed(b), $signed(res16), rpar16, err16, lat);
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        bad, ba, bb;
        logic [7:0]  qa [3];
        logic [7:0]  qb [3];
        logic [15:0] last8;
        int          idx;

        rst_n = 1'b1;
        a16 = '0; b16 = '0; pa16 = 1'b0; pb16 = 1'b0; req16 = 1'b0;
        a8 = '0; b8 = '0; pa8 = 1'b0; pb8 = 1'b0; req8 = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ack16", 64'(ack16), 64'(1'b0));
        chk("rst_rdy16", 64'(rdy16), 64'(1'b0));
        chk("rst_res16", 64'(res16), 64'(32'h0));
        chk("rst_rpar16", 64'(rpar16), 64'(1'b0));
        chk("rst_err16", 64'(err16), 64'(1'b0));
        chk("rst_res8", 64'(res8), 64'(16'h0));

        // First capture on the very edge reset is released for.
        op16(16'd3, 16'hFFFB, 1'b0, 1'b1, 1'b0, 1'b1);
        op16(16'h8000, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0);
        op16(16'd3, 16'hFFFB, 1'b1, 1'b1, 1'b0, 1'b0);
        op16(16'h7FFF, 16'h8000, 1'b1, 1'b1, 1'b1, 1'b0);
        op16(16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 24; i++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            ba  = bad & 1'($urandom_range(0, 1));
            bb  = bad & ~ba;
            op16(ra, rb, (^ra) ^ ba, (^rb) ^ bb, 1'($urandom_range(0, 1)), 1'b0);
        end

        // Abort mid-CALC with reset, then a clean operation afterwards.
        op16(16'd3, 16'hFFFB, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        a16 = 16'd1234; b16 = 16'd567; pa16 = ^a16; pb16 = ^b16; req16 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            req16 = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("abort_ack16", 64'(ack16), 64'(1'b0));
        chk("abort_rdy16", 64'(rdy16), 64'(1'b0));
        chk("abort_res16", 64'(res16), 64'(32'h0));
        chk("abort_rpar16", 64'(rpar16), 64'(1'b0));
        chk("abort_err16", 64'(err16), 64'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            chk("abort_no_rdy16", 64'(rdy16), 64'(1'b0));
        end
        $display("abort: reset asserted in CALC, no result reported");
        op16(16'hFF85, 16'd29, ^16'hFF85, ^16'd29, 1'b0, 1'b0);

        // Back-to-back WIDTH=8 operations with req held high.
        qa[0] = 8'h80; qb[0] = 8'h80;
        for (int i = 1; i < 3; i++) begin
            qa[i] = 8'($urandom);
            qb[i] = 8'($urandom);
        end
        last8 = '0;
        @(negedge clk);
        a8 = qa[0]; b8 = qb[0]; pa8 = ^qa[0]; pb8 = ^qb[0]; req8 = 1'b1;
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            chk("ack8_spacing", 64'(ack8), 64'((c % 11) == 1));
            chk("rdy8_spacing", 64'(rdy8), 64'((c % 11) == 10));
            if ((c % 11) == 10) begin
                last8 = ref8(qa[c / 11], qb[c / 11]);
                $display("op8 a=%0d b=%0d result=%0d", $signed(qa[c / 11]),
                         $signed(qb[c / 11]), $signed(res8));
            end
            chk("res8_value", 64'(res8), 64'(last8));
            chk("rpar8", 64'(rpar8), 64'(^last8));
            chk("err8", 64'(err8), 64'(1'b0));
            if ((c % 11) == 1) begin
                idx = c / 11 + 1;
                if (idx < 3) begin
                    a8 = qa[idx]; b8 = qb[idx]; pa8 = ^qa[idx]; pb8 = ^qb[idx];
                end else begin
                    req8 = 1'b0;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
